sync_updown_counter: RTL and testbench



---
 rtl/sync_updown_counter.sv | 120 ++++++++++++
 tb/tb_sync_updown_counter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_updown_counter.sv
// Parametrised up-wrap / down-wrap / bounce counter with programmable limits,
// parallel load, a registered wrap/turn pulse and combinational limit flags.
module sync_updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit_lo,
  input  logic [WIDTH-1:0] limit_hi,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             wrap,
  output logic             at_lo,
  output logic             at_hi
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  logic [WIDTH-1:0] count_next;
  logic             dir_next;
  logic             wrap_next;
  mode_t            mode_sel;

  assign mode_sel = mode_t'(mode);

  // Next-state selection; load beats enable, and empty ranges park on limit_lo.
  always_comb begin
    count_next = count;
    dir_next   = dir;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = load_value;
    end else if (enable && (mode_sel != MODE_HOLD)) begin
      if (limit_hi <= limit_lo) begin
        count_next = limit_lo;
      end else begin
        case (mode_sel)
          MODE_UP: begin
            dir_next = 1'b1;
            if (count >= limit_hi) begin
              count_next = limit_lo;
              wrap_next  = (count == limit_hi);
            end else begin
              count_next = count + 1'b1;
            end
          end
          MODE_DOWN: begin
            dir_next = 1'b0;
            if (count <= limit_lo) begin
              count_next = limit_hi;
              wrap_next  = (count == limit_lo);
            end else begin
              count_next = count - 1'b1;
            end
          end
          MODE_BOUNCE: begin
            // Turning at an endpoint steps away immediately so it is never repeated.
            if (dir) begin
              if (count == limit_hi) begin
                count_next = count - 1'b1;
                dir_next   = 1'b0;
                wrap_next  = 1'b1;
              end else if (count > limit_hi) begin
                count_next = limit_hi;
                dir_next   = 1'b0;
              end else if (count < limit_lo) begin
                count_next = limit_lo;
                dir_next   = 1'b1;
              end else begin
                count_next = count + 1'b1;
              end
            end else begin
              if (count == limit_lo) begin
                count_next = count + 1'b1;
                dir_next   = 1'b1;
                wrap_next  = 1'b1;
              end else if (count < limit_lo) begin
                count_next = limit_lo;
                dir_next   = 1'b1;
              end else if (count > limit_hi) begin
                count_next = limit_hi;
                dir_next   = 1'b0;
              end else begin
                count_next = count - 1'b1;
              end
            end
          end
          default: begin
            count_next = count;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count <= '0;
      dir   <= 1'b1;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      dir   <= dir_next;
      wrap  <= wrap_next;
    end
  end

  assign at_lo = (count == limit_lo);
  assign at_hi = (count == limit_hi);

endmodule

// File: tb/tb_sync_updown_counter.sv
// Table-driven bench for sync_updown_counter (WIDTH=4) with hand-written
// sequences for the asynchronous clear corner case.
module tb_sync_updown_counter;

  logic       clock;
  logic       clear;
  logic       enable;
  logic [1:0] mode;
  logic [3:0] limit_lo;
  logic [3:0] limit_hi;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] count;
  logic       dir;
  logic       wrap;
  logic       at_lo;
  logic       at_hi;

  int checks;
  int failures;

  typedef struct {
    logic       clr;
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic [1:0] md;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] ec;
    logic       ed;
    logic       ew;
    logic       el;
    logic       eh;
  } vec_t;

  vec_t vecs[$];

  sync_updown_counter #(.WIDTH(4)) dut (
    .clock(clock),
    .clear(clear),
    .enable(enable),
    .mode(mode),
    .limit_lo(limit_lo),
    .limit_hi(limit_hi),
    .load(load),
    .load_value(load_value),
    .count(count),
    .dir(dir),
    .wrap(wrap),
    .at_lo(at_lo),
    .at_hi(at_hi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(int clr, int ld, int lv, int en, int md, int lo, int hi,
                              int ec, int ed, int ew, int el, int eh);
    vec_t v;
    v.clr = clr[0];
    v.ld  = ld[0];
    v.lv  = lv[3:0];
    v.en  = en[0];
    v.md  = md[1:0];
    v.lo  = lo[3:0];
    v.hi  = hi[3:0];
    v.ec  = ec[3:0];
    v.ed  = ed[0];
    v.ew  = ew[0];
    v.el  = el[0];
    v.eh  = eh[0];
    return v;
  endfunction

  task automatic checkOutput(input string name, input int step, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s step=%0d actual=%0d expected=%0d", name, step, actual, expected);
    end
  endtask

  task automatic checkAll(input int step, input vec_t v);
    checkOutput("count", step, int'(count), int'(v.ec));
    checkOutput("dir",   step, int'(dir),   int'(v.ed));
    checkOutput("wrap",  step, int'(wrap),  int'(v.ew));
    checkOutput("at_lo", step, int'(at_lo), int'(v.el));
    checkOutput("at_hi", step, int'(at_hi), int'(v.eh));
  endtask

  // A clr row pulses clear between edges; other rows consume one clock edge.
  task automatic applyStimulus(input int step, input vec_t v);
    load       = v.ld;
    load_value = v.lv;
    enable     = v.en;
    mode       = v.md;
    limit_lo   = v.lo;
    limit_hi   = v.hi;
    if (v.clr) begin
      clear = 1'b1;
      #1;
      checkAll(step, v);
      clear = 1'b0;
      #1;
    end else begin
      @(posedge clock);
      #1;
      checkAll(step, v);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    clear      = 1'b1;
    enable     = 1'b0;
    mode       = 2'b00;
    limit_lo   = 4'd0;
    limit_hi   = 4'd15;
    load       = 1'b0;
    load_value = 4'd0;

    #12;
    clear = 1'b0;

    // Load 5, then clear asynchronously mid-cycle with no clock edge.
    load       = 1'b1;
    load_value = 4'd5;
    @(posedge clock);
    #1;
    checkOutput("pre_clear_count", 0, int'(count), 5);
    load = 1'b0;
    #2;
    clear = 1'b1;
    #1;
    checkOutput("async_clear_count", 0, int'(count), 0);
    checkOutput("async_clear_dir",   0, int'(dir),   1);
    checkOutput("async_clear_wrap",  0, int'(wrap),  0);
    clear    = 1'b0;
    mode     = 2'b00;
    limit_lo = 4'd0;
    limit_hi = 4'd15;
    enable   = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clock);
      #1;
      checkOutput("post_clear_count", i, int'(count), i);
    end

    // Up-wrap lo=2 hi=5
    vecs.push_back(mk(0,1,2,1,0,2,5, 2,1,0,1,0));
    vecs.push_back(mk(0,0,0,1,0,2,5, 3,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,2,5, 4,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,2,5, 5,1,0,0,1));
    vecs.push_back(mk(0,0,0,1,0,2,5, 2,1,1,1,0));
    vecs.push_back(mk(0,0,0,1,0,2,5, 3,1,0,0,0));
    // Down-wrap from out-of-range 9
    vecs.push_back(mk(0,1,9,1,1,2,5, 9,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,1,2,5, 8,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,1,2,5, 7,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,1,2,5, 6,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,1,2,5, 5,0,0,0,1));
    vecs.push_back(mk(0,0,0,1,1,2,5, 4,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,1,2,5, 3,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,1,2,5, 2,0,0,1,0));
    vecs.push_back(mk(0,0,0,1,1,2,5, 5,0,1,0,1));
    // Switching to up-wrap overwrites dir
    vecs.push_back(mk(0,0,0,1,0,2,5, 2,1,1,1,0));
    // Bounce lo=0 hi=3 from reset
    vecs.push_back(mk(1,0,0,0,2,0,3, 0,1,0,1,0));
    vecs.push_back(mk(0,0,0,1,2,0,3, 1,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,2,0,3, 2,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,2,0,3, 3,1,0,0,1));
    vecs.push_back(mk(0,0,0,1,2,0,3, 2,0,1,0,0));
    vecs.push_back(mk(0,0,0,1,2,0,3, 1,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,2,0,3, 0,0,0,1,0));
    vecs.push_back(mk(0,0,0,1,2,0,3, 1,1,1,0,0));
    // Load priority, enable hold, mode hold
    vecs.push_back(mk(0,1,7,1,2,0,3, 7,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,2,0,3, 7,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,2,0,3, 7,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,2,0,3, 7,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,3,0,3, 7,1,0,0,0));
    // Degenerate limits lo=hi=6
    vecs.push_back(mk(0,1,3,1,0,6,6, 3,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,6,6, 6,1,0,1,1));
    vecs.push_back(mk(0,0,0,1,0,6,6, 6,1,0,1,1));
    // Bounce clamps from outside the range
    vecs.push_back(mk(0,0,0,1,2,2,5, 5,0,0,0,1));
    vecs.push_back(mk(0,0,0,1,2,2,5, 4,0,0,0,0));
    vecs.push_back(mk(0,1,0,1,2,2,5, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,2,2,5, 2,1,0,1,0));
    vecs.push_back(mk(0,0,0,1,2,2,5, 3,1,0,0,0));
    // Wraps from outside the range give no pulse
    vecs.push_back(mk(0,1,9,1,0,2,5, 9,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,2,5, 2,1,0,1,0));
    vecs.push_back(mk(0,1,0,1,1,2,5, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,1,2,5, 5,0,0,0,1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(i + 10, vecs[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
